// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the dual-lane MAC sequencing controller.
package mac_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_STEP,
    S_DZ,
    S_DRAIN,
    S_CAPT,
    S_SHLD,
    S_OUT0,
    S_OUT1
  } state_t;

  localparam logic PH_P0 = 1'b0;
  localparam logic PH_P1 = 1'b1;

  localparam int BYTES_PER_ELEM = 4;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_ELEM - 1);

  localparam int DRAIN_CYC = 2;
  localparam int CAPT_CYC  = 1;

  // One-hot p_reg load strobe, bit k drives ld(k+1).
  function automatic logic [3:0] byte_strobe(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable element down-counter with a zero flag.
module mac_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for the dual-lane MAC datapath (p_regs, MAC lanes, PISO/AF).
// Optional feature: define MAC_SEQ_ABORT_EN to add the 'abort' input.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MAC_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       mac_in,
  output logic             ld1,
  output logic             ld2,
  output logic             ld3,
  output logic             ld4,
  output logic             mac_clken,
  output logic             mac_clr,
  output logic             piso_ld,
  output logic             res_valid,
  output logic             res_lane,
  output logic             busy,
  output logic             done
);

  localparam int WAIT_W = 2;

  state_t            state;
  logic              phase;
  logic [1:0]        byte_idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              abort_exit;
  logic [LEN_W-1:0]  len_eff;

  assign len_eff  = (len == '0) ? LEN_W'(1) : len;
  assign cnt_load = (state == S_IDLE) && start;
  // Decrement as byte 3 finishes so the zero flag is already valid in STEP.
  assign cnt_dec  = (state == S_LOAD) && (phase == PH_P1) && (byte_idx == LAST_BYTE);

  mac_seq_cnt #(.W(LEN_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (len_eff),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef MAC_SEQ_ABORT_EN
  logic abort_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abort_pend <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      abort_pend <= 1'b1;
    end else if (state == S_CLR) begin
      abort_pend <= 1'b0;
    end
  end

  assign abort_exit = abort_pend;
`else
  assign abort_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase     <= PH_P0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
      mac_in    <= '0;
      {ld4, ld3, ld2, ld1} <= '0;
      in_ready  <= 1'b0;
      mac_clken <= 1'b0;
      mac_clr   <= 1'b1;
      piso_ld   <= 1'b0;
      res_valid <= 1'b0;
      res_lane  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      {ld4, ld3, ld2, ld1} <= '0;
      in_ready  <= 1'b0;
      mac_clken <= 1'b0;
      mac_clr   <= 1'b0;
      piso_ld   <= 1'b0;
      res_valid <= 1'b0;
      res_lane  <= 1'b0;
      done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CLR;
            mac_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_CLR: begin
          if (abort_exit) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= S_LOAD;
            phase    <= PH_P0;
            byte_idx <= '0;
            in_ready <= 1'b1;
          end
        end

        // Strobe rises one edge after mac_in settles, so p_regs never see a changing bus.
        S_LOAD: begin
          if (phase == PH_P0) begin
            if (in_valid && in_ready) begin
              mac_in <= in_data;
              phase  <= PH_P1;
            end else begin
              in_ready <= 1'b1;
            end
          end else begin
            {ld4, ld3, ld2, ld1} <= byte_strobe(byte_idx);
            phase <= PH_P0;
            if (byte_idx == LAST_BYTE) begin
              state     <= S_STEP;
              mac_clken <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              in_ready <= 1'b1;
            end
          end
        end

        S_STEP: begin
          phase    <= PH_P0;
          byte_idx <= '0;
          if (cnt_zero) begin
            state <= S_DZ;
          end else begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
          end
        end

        // Zero both lane 'a' operands so the drain cycles add nothing further.
        S_DZ: begin
          if (phase == PH_P0) begin
            mac_in <= '0;
            phase  <= PH_P1;
          end else begin
            {ld4, ld3, ld2, ld1} <= byte_strobe(2'd0) | byte_strobe(2'd2);
            phase     <= PH_P0;
            state     <= S_DRAIN;
            mac_clken <= 1'b1;
            wait_cnt  <= WAIT_W'(DRAIN_CYC - 1);
          end
        end

        S_DRAIN: begin
          if (wait_cnt == '0) begin
            state    <= S_CAPT;
            wait_cnt <= WAIT_W'(CAPT_CYC - 1);
          end else begin
            wait_cnt  <= wait_cnt - WAIT_W'(1);
            mac_clken <= 1'b1;
          end
        end

        S_CAPT: begin
          if (wait_cnt == '0) begin
            state   <= S_SHLD;
            piso_ld <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end

        S_SHLD: begin
          state     <= S_OUT0;
          res_valid <= 1'b1;
          res_lane  <= 1'b0;
        end

        S_OUT0: begin
          state     <= S_OUT1;
          res_valid <= 1'b1;
          res_lane  <= 1'b1;
          done      <= 1'b1;
        end

        S_OUT1: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

`ifdef MAC_SEQ_ABORT_EN
      if (abort && (state != S_IDLE)) begin
        state     <= S_CLR;
        mac_clr   <= 1'b1;
        busy      <= 1'b1;
        {ld4, ld3, ld2, ld1} <= '0;
        in_ready  <= 1'b0;
        mac_clken <= 1'b0;
        piso_ld   <= 1'b0;
        res_valid <= 1'b0;
        res_lane  <= 1'b0;
        done      <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural p_reg/MAC/PISO datapath model.
module tb_mac_seq_ctrl;

  localparam int LEN_W = 8;

  typedef struct {
    int          len_in;
    int          eff_len;
    logic [95:0] bytes;
    int          stall_idx;
    int          stall_n;
    bit          start_mid;
    int          exp_lane1;
    int          exp_lane2;
    int          exp_done;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       mac_in;
  logic             ld1, ld2, ld3, ld4;
  logic             mac_clken;
  logic             mac_clr;
  logic             piso_ld;
  logic             res_valid;
  logic             res_lane;
  logic             busy;
  logic             done;
`ifdef MAC_SEQ_ABORT_EN
  logic             abort;
`endif

  int checks;
  int errors;

  mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MAC_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mac_in    (mac_in),
    .ld1       (ld1),
    .ld2       (ld2),
    .ld3       (ld3),
    .ld4       (ld4),
    .mac_clken (mac_clken),
    .mac_clr   (mac_clr),
    .piso_ld   (piso_ld),
    .res_valid (res_valid),
    .res_lane  (res_lane),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: p_regs on strobe rising edge, two-stage MAC lanes, capture into PISO.
  logic [7:0]  pa1, pb1, pa2, pb2;
  logic [15:0] m1, m2;
  logic [16:0] acc1, acc2;
  logic [15:0] piso;

  always @(posedge ld1) pa1 <= mac_in;
  always @(posedge ld2) pb1 <= mac_in;
  always @(posedge ld3) pa2 <= mac_in;
  always @(posedge ld4) pb2 <= mac_in;

  always @(posedge clk) begin
    if (mac_clr) begin
      m1   <= '0;
      m2   <= '0;
      acc1 <= '0;
      acc2 <= '0;
    end else if (mac_clken) begin
      m1   <= pa1 * pb1;
      m2   <= pa2 * pb2;
      acc1 <= acc1 + {1'b0, m1};
      acc2 <= acc2 + {1'b0, m2};
    end
    if (piso_ld) piso <= {acc1[16:9], acc2[16:9]};
  end

  // Strobe monitor: rise counts, strobes held longer than a cycle, rises while mac_in moves.
  int         ld_rise[4];
  int         hold_err;
  int         chg_err;
  logic [3:0] prev_ld;
  logic [7:0] prev_mac;

  initial begin
    for (int i = 0; i < 4; i++) ld_rise[i] = 0;
    hold_err = 0;
    chg_err  = 0;
    prev_ld  = '0;
    prev_mac = '0;
  end

  always @(negedge clk) begin
    logic [3:0] cur;
    cur = {ld4, ld3, ld2, ld1};
    for (int i = 0; i < 4; i++) begin
      if (cur[i] && !prev_ld[i]) ld_rise[i]++;
      if (cur[i] && prev_ld[i]) hold_err++;
    end
    if (((cur & ~prev_ld) != 4'd0) && (mac_in != prev_mac)) chg_err++;
    prev_ld  = cur;
    prev_mac = mac_in;
  end

  vec_t vecs[8];
  int   base_rise[4];
  int   base_hold, base_chg;
  int   done_cyc, res_cnt, order_bad, got1, got2;
  int   busy_after, done_after, clr_after, idle_cyc;
  int   abort_cyc;

  function automatic vec_t make_vec(int len_in, int eff_len, logic [95:0] bytes,
                                    int stall_idx, int stall_n, bit start_mid,
                                    int e1, int e2, int edone);
    vec_t v;
    v.len_in    = len_in;
    v.eff_len   = eff_len;
    v.bytes     = bytes;
    v.stall_idx = stall_idx;
    v.stall_n   = stall_n;
    v.start_mid = start_mid;
    v.exp_lane1 = e1;
    v.exp_lane2 = e2;
    v.exp_done  = edone;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full command: start pulse, operand feed with optional stall, result capture.
  task automatic applyStimulus(input vec_t v);
    int cyc, idx, stall_left, lim;
    for (int i = 0; i < 4; i++) base_rise[i] = ld_rise[i];
    base_hold  = hold_err;
    base_chg   = chg_err;
    done_cyc   = -1;
    res_cnt    = 0;
    order_bad  = 0;
    got1       = -1;
    got2       = -1;
    clr_after  = 0;
    idle_cyc   = -1;
    cyc        = 0;
    idx        = 0;
    stall_left = v.stall_n;
    lim        = (abort_cyc >= 0) ? 30 : 200;

    @(negedge clk);
    len      = LEN_W'(v.len_in);
    start    = 1'b1;
    in_valid = 1'b0;

    while (done_cyc < 0 && cyc < lim) begin
      @(negedge clk);
      cyc++;
      start = v.start_mid && (cyc == 5);
      if (start) len = 8'd7;
`ifdef MAC_SEQ_ABORT_EN
      abort = (cyc == abort_cyc);
`endif
      if (res_valid) begin
        res_cnt++;
        if (!res_lane) begin
          got2 = int'(piso[7:0]);
          if (res_cnt != 1) order_bad = 1;
        end else begin
          got1 = int'(piso[15:8]);
          if (res_cnt != 2) order_bad = 1;
        end
      end
      if (cyc > 1 && mac_clr) clr_after++;
      if (cyc > 1 && !busy && idle_cyc < 0) idle_cyc = cyc;
      if (done) done_cyc = cyc;
      if (idx < 4 * v.eff_len) begin
        if (idx == v.stall_idx && stall_left > 0 && in_ready) begin
          in_valid = 1'b0;
          stall_left--;
        end else begin
          in_valid = 1'b1;
          in_data  = v.bytes[idx*8 +: 8];
          if (in_ready) idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    busy_after = int'(busy);
    done_after = int'(done);
  endtask

  task automatic checkRun(input vec_t v, input int n);
    checkOutput($sformatf("v%0d done_cycle", n), done_cyc, v.exp_done);
    checkOutput($sformatf("v%0d res_valid_count", n), res_cnt, 2);
    checkOutput($sformatf("v%0d lane_order_bad", n), order_bad, 0);
    checkOutput($sformatf("v%0d lane1_byte", n), got1, v.exp_lane1);
    checkOutput($sformatf("v%0d lane2_byte", n), got2, v.exp_lane2);
    checkOutput($sformatf("v%0d busy_after_done", n), busy_after, 0);
    checkOutput($sformatf("v%0d done_one_cycle", n), done_after, 0);
    checkOutput($sformatf("v%0d ld1_rises", n), ld_rise[0] - base_rise[0], v.eff_len + 1);
    checkOutput($sformatf("v%0d ld2_rises", n), ld_rise[1] - base_rise[1], v.eff_len);
    checkOutput($sformatf("v%0d ld3_rises", n), ld_rise[2] - base_rise[2], v.eff_len + 1);
    checkOutput($sformatf("v%0d ld4_rises", n), ld_rise[3] - base_rise[3], v.eff_len);
    checkOutput($sformatf("v%0d strobe_held", n), hold_err - base_hold, 0);
    checkOutput($sformatf("v%0d strobe_vs_mac_in", n), chg_err - base_chg, 0);
  endtask

  initial begin
    int idx;
    checks    = 0;
    errors    = 0;
    abort_cyc = -1;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_data   = '0;
    in_valid  = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
    abort     = 1'b0;
`endif

    vecs[0] = make_vec(1, 1, 96'h0000_0000_0000_0000_FFFF_C8C8, -1, 0, 1'b0, 78, 127, 18);
    vecs[1] = make_vec(2, 2, 96'h0000_0000_FFFF_FFFF_FFFF_FFFF, -1, 0, 1'b0, 254, 254, 27);
    vecs[2] = make_vec(1, 1, 96'h0000_0000_0000_0000_FFFF_C8C8,  2, 3, 1'b0, 78, 127, 21);
    vecs[3] = make_vec(0, 1, 96'h0000_0000_0000_0000_FFFF_C8C8, -1, 0, 1'b1, 78, 127, 18);
    vecs[4] = make_vec(1, 1, 96'h0000_0000_0000_0000_03FF_3264, -1, 0, 1'b0, 9, 1, 18);
    vecs[5] = make_vec(2, 2, 96'h0000_0000_0101_6464_FFFF_C8C8, -1, 0, 1'b0, 97, 127, 27);
    vecs[6] = make_vec(3, 3, 96'h8080_8080_8080_8080_8080_8080,  5, 2, 1'b0, 96, 96, 38);
    vecs[7] = make_vec(3, 3, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, -1, 0, 1'b0, 125, 125, 36);

    #2 rst = 1'b0;
    #1;
    checkOutput("reset mac_clr", 32'(mac_clr), 1);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset in_ready", 32'(in_ready), 0);
    checkOutput("reset strobes", 32'({ld4, ld3, ld2, ld1, mac_clken, piso_ld}), 0);
    checkOutput("reset res_valid", 32'({res_valid, res_lane, done}), 0);
    checkOutput("reset mac_in", 32'(mac_in), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 8; n++) begin
      applyStimulus(vecs[n]);
      checkRun(vecs[n], n);
    end

    // Reset asserted while loading byte 1; the following run must start clean.
    @(negedge clk);
    len   = 8'd1;
    start = 1'b1;
    idx   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (idx == 1 && in_ready) break;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      if (in_ready) idx++;
    end
    in_valid = 1'b0;
    checkOutput("rst_mid ld1_before", 32'(ld1), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid strobes", 32'({ld4, ld3, ld2, ld1}), 0);
    checkOutput("rst_mid busy", 32'(busy), 0);
    checkOutput("rst_mid in_ready", 32'(in_ready), 0);
    checkOutput("rst_mid mac_clr", 32'(mac_clr), 1);
    checkOutput("rst_mid res_valid", 32'({res_valid, done}), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[0]);
    checkRun(vecs[0], 8);

`ifdef MAC_SEQ_ABORT_EN
    abort_cyc = 13;
    applyStimulus(vecs[0]);
    abort_cyc = -1;
    checkOutput("abort res_valid_count", res_cnt, 0);
    checkOutput("abort done_cycle", done_cyc, -1);
    checkOutput("abort mac_clr_cycles", clr_after, 1);
    checkOutput("abort idle_cycle", idle_cyc, 15);
    checkOutput("abort busy_after", busy_after, 0);
    applyStimulus(vecs[4]);
    checkRun(vecs[4], 9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the dual-lane MAC datapath: the `p_reg` operand registers, two `example_mac` lanes, the result capture registers and the `PISO`/`AF` output path. It accepts a start command and a vector length, then pulls operand bytes over a valid/ready stream and drives the p_reg loads. It issues the MAC clock enables, drains the MAC pipeline, and triggers the PISO load. The result is reported as two byte-valid strobes. It replaces free-running top-level control of `ld1..ld4`, `clken` and `ld`.

## Interface
- `LEN_W`, default 8: width of vector-length field (max length 2^LEN_W−1).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `len`  in  LEN_W  element count, latched on `start`; 0 treated as 1.
- `in_data`  in  8  operand byte; per element order: lane1 a, lane1 b, lane2 a, lane2 b.
- `in_valid` / `in_ready`  in / out  1  operand handshake; transfer when both high at a clk edge.
- `mac_in`  out  8  registered operand bus to all p_regs.
- `ld1..ld4`  out  1 each  p_reg load strobes (p_reg captures on strobe rising edge).
- `mac_clken`  out  1  clken for both MAC lanes.
- `mac_clr`  out  1  active-high clear; top ORs with `~rst` into the datapath `rst`.
- `piso_ld`  out  1  PISO `ld`.
- `res_valid`  out  1  AF output valid this cycle.
- `res_lane`  out  1  0 = lane2 result byte (PISO low byte), 1 = lane1.
- `busy`  out  1  high in all states except IDLE.
- `done`  out  1  one-cycle pulse after the last result byte.

## Operation
- All outputs are registered. Reset value of every output is 0, except `mac_clr` = 1 while `rst` is low.
- FSM states:
  - IDLE: on `start`, go to CLR.
  - CLR: `mac_clr` = 1 for 1 cycle; go to LOAD.
  - LOAD: byte k = 0..3, two phases per byte.
    - P0: `in_ready` = 1; on handshake, `mac_in` <= `in_data`; go to P1. Stalls while `in_valid` = 0.
    - P1: `ld(k+1)` <= 1.
    - The strobe is high for exactly the following cycle. `mac_in` is never updated in a cycle where that strobe rises.
  - STEP: entered after byte 3 P1; `mac_clken` = 1 for 1 cycle. Then decrement the element counter: if nonzero go to LOAD byte 0, else go to DZ.
  - DZ: P0 drives `mac_in` <= 0 with no handshake; P1 raises `ld1`. This zeroes lane1 a and lane2 is unaffected, so the lane2 drain products become the lane2 a duplicates. Therefore DZ zeroes both `ld1` and `ld3` (two strobes in the same P1).
  - DRAIN1, DRAIN2: `mac_clken` = 1 in each (flushes `multa_reg`).
  - CAPT: 1 idle cycle; the datapath captures bits [16:9] of each accumulator.
  - SHLD: `piso_ld` = 1.
  - OUT0: `res_valid` = 1, `res_lane` = 0.
  - OUT1: `res_valid` = 1, `res_lane` = 1, `done` = 1. Then go to IDLE.
- `start` outside IDLE is ignored.
- `in_ready` is 0 outside LOAD P0.
- Counter arithmetic: unsigned LEN_W bits, loaded with max(`len`, 1).

## Timing
- Full-rate element cost: 9 cycles (4 bytes × 2 + STEP).
- `start` → first `in_ready`: 2 cycles.
- Last STEP → first `res_valid`: 7 cycles.
- Total with no stalls: 1 + 9·L + 7 + 1 cycles from `start` edge to `done`.
- Each `in_valid` low cycle in P0 adds exactly 1 cycle.
- Async `rst` assertion mid-operation: immediate return to IDLE, strobes drop, datapath cleared through `mac_clr`. No partial result is reported.
- Accumulator overflow beyond 17 bits wraps; the controller does not detect it.

## Configuration
- `MAC_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - In any non-IDLE state, `abort` high at an edge goes to CLR-then-IDLE: one `mac_clr` cycle, no `res_valid`, no `done`.
- Undefined: port absent; the only exit from an operation is completion or reset.

## Structure
- Shared package `mac_seq_pkg`: FSM state enum, byte-phase constants, and the drain/capture cycle counts (DRAIN_CYC = 2, CAPT_CYC = 1).
- One sub-module, `mac_seq_cnt`: loadable down-counter for elements with a zero flag.
- Everything else lives in the FSM.

## Test plan
- L=1; bytes 200, 200, 255, 255 → `res_valid` twice: OUT0 AF input 127 (lane2), OUT1 AF input 78 (lane1); `done` at cycle 18 after `start`.
- L=2; all bytes 255 → lane bytes 254, 254; `done` at cycle 27.
- L=1 with `in_valid` low 3 cycles before byte 2 → same results, `done` delayed exactly 3 cycles. No `ld3` rise while `mac_in` changes.
- `rst` low during LOAD byte 1 → all strobes 0 immediately, `busy` = 0. A subsequent L=1 run gives correct results (no stale accumulation).
- `start` pulsed while busy, and `len` = 0 → ignored, and treated as L=1, respectively.
- `MAC_SEQ_ABORT_EN`: `abort` in DRAIN1 → one `mac_clr` pulse, no `res_valid`/`done`, back in IDLE in 2 cycles.
